// File: rtl/mem_map_pkg.sv
// Shared constants for the mem_map CPU memory map.
// Holds the I/O page register offsets, STATUS/CTRL bit positions, the reset values
// and a helper that packs the STATUS byte.
package mem_map_pkg;

  // Register offsets within the 16-byte I/O page
  typedef enum logic [3:0] {
    IoTxData = 4'h0,
    IoStatus = 4'h1,
    IoTmrLo  = 4'h2,
    IoTmrHi  = 4'h3,
    IoCtrl   = 4'h4
  } io_off_e;

  // STATUS bit positions
  localparam int unsigned StatusEmptyBit   = 0;
  localparam int unsigned StatusFullBit    = 1;
  localparam int unsigned StatusTmrFlagBit = 2;
  localparam int unsigned StatusOvfBit     = 3;

  // CTRL bit positions
  localparam int unsigned CtrlTmrEnBit = 0;
  localparam int unsigned CtrlIrqEnBit = 1;

  // Reset values
  localparam logic [7:0]  DataOutRst = 8'h00;
  localparam logic [15:0] TmrRst     = 16'hFFFF;

  function automatic logic [7:0] status_byte(input logic ovf, input logic tmr_flag,
                                             input logic full, input logic empty);
    logic [7:0] s;
    s                   = 8'h00;
    s[StatusEmptyBit]   = empty;
    s[StatusFullBit]    = full;
    s[StatusTmrFlagBit] = tmr_flag;
    s[StatusOvfBit]     = ovf;
    return s;
  endfunction

endpackage

// File: rtl/mem_map_if.sv
// CPU bus plus TX stream and interrupt of mem_map.
// Signals:
//   Address/WE/DataIn : CPU byte address, write strobe, write data
//   DataOut           : registered read data
//   tx_data/tx_valid  : head of TX FIFO and non-empty flag
//   tx_ready          : sink accepts tx_data
//   irq               : timer interrupt
// Modports: slave (the memory map), master (the CPU/sink driving it).
interface mem_map_if;
  logic [15:0] Address;
  logic        WE;
  logic [7:0]  DataIn;
  logic [7:0]  DataOut;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq;

  modport slave (
    input  Address, WE, DataIn, tx_ready,
    output DataOut, tx_data, tx_valid, irq
  );

  modport master (
    output Address, WE, DataIn, tx_ready,
    input  DataOut, tx_data, tx_valid, irq
  );
endinterface

// File: rtl/mem_map_tx_fifo.sv
// tx_fifo: byte FIFO feeding the TX stream of mem_map.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (empties the FIFO)
//   push_i/data_i : write request and data; dropped when full unless pop_i same edge
//   pop_i         : read request; ignored when empty
//   data_o        : head entry, 8'h00 when empty
//   full_o/empty_o/count_o : occupancy
module tx_fifo #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CntW  = AW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [7:0]      data_i,
  input  logic            pop_i,
  output logic [7:0]      data_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push_ok, pop_ok;

  always_comb begin
    full_o  = (cnt_q == FullCnt);
    empty_o = (cnt_q == '0);
    count_o = cnt_q;
    data_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];
    // A full FIFO still takes a push when the head leaves on the same edge
    push_ok = push_i && (!full_o || pop_i);
    pop_ok  = pop_i && !empty_o;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      cnt_d = cnt_q + CntW'(1);
    else if (!push_ok && pop_ok) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; pointer reset is enough to discard contents
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mem_map.sv
// mem_map: 64 KiB byte RAM with a 16-byte I/O page holding a TX FIFO, a reloading
// down-counter timer and a control register.
// Ports:
//   CLK    : clock, all state on rising edge
//   R      : asynchronous active-low reset
//   bus_io : CPU bus (Address/WE/DataIn/DataOut), TX stream, irq
// Reads are registered (one-cycle latency) and read-before-write.
module mem_map
  import mem_map_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] IO_BASE    = 16'hFF00
) (
  input  logic     CLK,
  input  logic     R,
  mem_map_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic            io_sel;
  logic [3:0]      io_off;
  logic            wr_txdata, wr_status, wr_tmr_lo, wr_tmr_hi, wr_ctrl;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_cnt;
  logic [7:0]      fifo_data;
  logic [7:0]      rdata;
  logic            tmr_tick;

  logic [7:0]  ram_q [65536];
  logic [7:0]  data_out_q, data_out_d;
  logic        overflow_q, overflow_d;
  logic        tmr_flag_q, tmr_flag_d;
  logic        tmr_en_q, tmr_en_d;
  logic        irq_en_q, irq_en_d;
  logic [15:0] reload_q, reload_d;
  logic [15:0] cnt_q, cnt_d;

  // Address decode
  always_comb begin
    io_sel    = (bus_io.Address[15:4] == IO_BASE[15:4]);
    io_off    = bus_io.Address[3:0];
    wr_txdata = bus_io.WE && io_sel && (io_off == IoTxData);
    wr_status = bus_io.WE && io_sel && (io_off == IoStatus);
    wr_tmr_lo = bus_io.WE && io_sel && (io_off == IoTmrLo);
    wr_tmr_hi = bus_io.WE && io_sel && (io_off == IoTmrHi);
    wr_ctrl   = bus_io.WE && io_sel && (io_off == IoCtrl);
    fifo_push = wr_txdata;
    fifo_pop  = bus_io.tx_ready && !fifo_empty;
  end

  tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (CLK),
    .rst_ni  (R),
    .push_i  (fifo_push),
    .data_i  (bus_io.DataIn),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Read mux from current state, so a write cycle returns the pre-write value
  always_comb begin
    rdata = 8'h00;
    if (io_sel) begin
      case (io_off)
        IoTxData: rdata = 8'(fifo_cnt);
        IoStatus: rdata = status_byte(overflow_q, tmr_flag_q, fifo_full, fifo_empty);
        IoTmrLo:  rdata = reload_q[7:0];
        IoTmrHi:  rdata = reload_q[15:8];
        IoCtrl: begin
          rdata               = 8'h00;
          rdata[CtrlTmrEnBit] = tmr_en_q;
          rdata[CtrlIrqEnBit] = irq_en_q;
        end
        default:  rdata = 8'h00;
      endcase
    end else begin
      rdata = ram_q[bus_io.Address];
    end
  end

  always_comb begin
    data_out_d = rdata;
    overflow_d = overflow_q;
    tmr_flag_d = tmr_flag_q;
    tmr_en_d   = tmr_en_q;
    irq_en_d   = irq_en_q;
    reload_d   = reload_q;
    cnt_d      = cnt_q;
    tmr_tick   = tmr_en_q && (cnt_q == 16'h0000);

    // Set beats a coincident STATUS clear for both sticky flags
    if (fifo_push && fifo_full && !fifo_pop) begin
      overflow_d = 1'b1;
    end else if (wr_status && bus_io.DataIn[StatusOvfBit]) begin
      overflow_d = 1'b0;
    end

    if (tmr_tick) begin
      tmr_flag_d = 1'b1;
    end else if (wr_status && bus_io.DataIn[StatusTmrFlagBit]) begin
      tmr_flag_d = 1'b0;
    end

    if (wr_tmr_lo) reload_d[7:0]  = bus_io.DataIn;
    if (wr_tmr_hi) reload_d[15:8] = bus_io.DataIn;

    // An explicit TMR_HI load overrides counting on that edge
    if (wr_tmr_hi) begin
      cnt_d = {bus_io.DataIn, reload_q[7:0]};
    end else if (tmr_tick) begin
      cnt_d = reload_q;
    end else if (tmr_en_q) begin
      cnt_d = cnt_q - 16'd1;
    end

    if (wr_ctrl) begin
      tmr_en_d = bus_io.DataIn[CtrlTmrEnBit];
      irq_en_d = bus_io.DataIn[CtrlIrqEnBit];
    end
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      data_out_q <= DataOutRst;
      overflow_q <= 1'b0;
      tmr_flag_q <= 1'b0;
      tmr_en_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      reload_q   <= TmrRst;
      cnt_q      <= TmrRst;
    end else begin
      data_out_q <= data_out_d;
      overflow_q <= overflow_d;
      tmr_flag_q <= tmr_flag_d;
      tmr_en_q   <= tmr_en_d;
      irq_en_q   <= irq_en_d;
      reload_q   <= reload_d;
      cnt_q      <= cnt_d;
    end
  end

  // RAM contents survive reset; I/O-page locations are never written
  always_ff @(posedge CLK) begin
    if (bus_io.WE && !io_sel) ram_q[bus_io.Address] <= bus_io.DataIn;
  end

  assign bus_io.DataOut  = data_out_q;
  assign bus_io.tx_data  = fifo_data;
  assign bus_io.tx_valid = !fifo_empty;
  assign bus_io.irq      = tmr_flag_q & irq_en_q;

endmodule

// File: tb/tb_mem_map.sv
// Scoreboard bench for mem_map: the driver queues expected DataOut / tx_data / status
// values as it issues stimulus; a single monitor on the falling edge pops and compares.
module tb_mem_map;

  logic clk;
  logic rst_n;

  mem_map_if bus ();

  mem_map #(
    .FIFO_DEPTH (8),
    .IO_BASE    (16'hFF00)
  ) dut (
    .CLK    (clk),
    .R      (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         sel;   // 0 DataOut, 1 tx_valid, 2 irq, 3 tx_data
    logic [7:0] exp;
    string      name;
  } imm_t;

  logic       chk_req;
  logic       chk_pipe;
  logic       done;
  logic [7:0] rd_exp_q[$];
  string      rd_name_q[$];
  logic [7:0] tx_exp_q[$];
  imm_t       imm_q[$];
  int         checks;
  int         errors;

  // Marks the cycle whose registered read result is due at the next falling edge
  always @(posedge clk) chk_pipe <= chk_req;

  // Monitor / scoreboard
  initial begin : monitor
    logic [7:0] got;
    imm_t       it;
    checks = 0;
    errors = 0;
    forever begin
      @(negedge clk);
      if (chk_pipe === 1'b1) begin
        if (rd_exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_underflow: DataOut %h with nothing expected", bus.DataOut);
        end else begin
          checks++;
          if (bus.DataOut !== rd_exp_q[0]) begin
            errors++;
            $display("FAIL %s: DataOut got %h expected %h", rd_name_q[0], bus.DataOut,
                     rd_exp_q[0]);
          end
          void'(rd_exp_q.pop_front());
          void'(rd_name_q.pop_front());
        end
      end
      if (rst_n === 1'b1 && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
        if (tx_exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: tx_data got %h with nothing expected", bus.tx_data);
        end else begin
          checks++;
          if (bus.tx_data !== tx_exp_q[0]) begin
            errors++;
            $display("FAIL tx_order: tx_data got %h expected %h", bus.tx_data, tx_exp_q[0]);
          end
          void'(tx_exp_q.pop_front());
        end
      end
      while (imm_q.size() > 0) begin
        it = imm_q.pop_front();
        case (it.sel)
          0:       got = bus.DataOut;
          1:       got = {7'b0, bus.tx_valid};
          2:       got = {7'b0, bus.irq};
          default: got = bus.tx_data;
        endcase
        checks++;
        if (got !== it.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", it.name, got, it.exp);
        end
      end
      if (done === 1'b1) begin
        if (rd_exp_q.size() != 0 || tx_exp_q.size() != 0) begin
          errors++;
          $display("FAIL leftover: rd %0d tx %0d expectations never seen", rd_exp_q.size(),
                   tx_exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic cyc(input logic [15:0] a, input logic we, input logic [7:0] d,
                     input logic chk, input logic [7:0] e, input string nm);
    bus.Address = a;
    bus.WE      = we;
    bus.DataIn  = d;
    chk_req     = chk;
    if (chk) begin
      rd_exp_q.push_back(e);
      rd_name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
    bus.WE  = 1'b0;
    chk_req = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cyc(a, 1'b1, d, 1'b0, 8'h00, "");
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e, input string nm);
    cyc(a, 1'b0, 8'h00, 1'b1, e, nm);
  endtask

  task automatic idle();
    cyc(16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, "");
  endtask

  task automatic imm(input int sel, input logic [7:0] e, input string nm);
    imm_t it;
    it.sel  = sel;
    it.exp  = e;
    it.name = nm;
    imm_q.push_back(it);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (tx_exp_q.size() > 0 && n < 40) begin
      idle();
      n++;
    end
  endtask

  // Stimulus
  initial begin : driver
    rst_n        = 1'b0;
    chk_req      = 1'b0;
    done         = 1'b0;
    bus.Address  = 16'h0000;
    bus.WE       = 1'b0;
    bus.DataIn   = 8'h00;
    bus.tx_ready = 1'b0;
    #1;
    imm(0, 8'h00, "rst_dataout");
    imm(1, 8'h00, "rst_tx_valid");
    imm(2, 8'h00, "rst_irq");
    imm(3, 8'h00, "rst_tx_data");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset register values
    rd(16'hFF01, 8'h01, "rst_status");
    rd(16'hFF02, 8'hFF, "rst_tmr_lo");
    rd(16'hFF03, 8'hFF, "rst_tmr_hi");
    rd(16'hFF04, 8'h00, "rst_ctrl");
    rd(16'hFF05, 8'h00, "unused_off");

    // RAM latency and read-before-write
    wr(16'h0201, 8'h00);
    wr(16'h0200, 8'hA5);
    rd(16'h0200, 8'hA5, "ram_read");
    cyc(16'h0201, 1'b1, 8'h3C, 1'b1, 8'h00, "ram_rbw");
    rd(16'h0201, 8'h3C, "ram_after_rbw");

    // Decode boundaries around the I/O page
    wr(16'hFEFF, 8'h77);
    wr(16'hFF10, 8'h66);
    wr(16'hFF0F, 8'h99);
    rd(16'hFEFF, 8'h77, "ram_below_io");
    rd(16'hFF10, 8'h66, "ram_above_io");
    rd(16'hFF0F, 8'h00, "io_unused_wr");

    // Overflow: nine pushes into an 8-deep FIFO
    for (int i = 1; i <= 8; i++) begin
      wr(16'hFF00, 8'(i));
      tx_exp_q.push_back(8'(i));
    end
    cyc(16'hFF00, 1'b1, 8'h09, 1'b1, 8'h08, "count_rbw_full");
    rd(16'hFF00, 8'h08, "count_full");
    rd(16'hFF01, 8'h0A, "status_full_ovf");
    bus.tx_ready = 1'b1;
    drain();
    bus.tx_ready = 1'b0;
    rd(16'hFF01, 8'h09, "status_empty_ovf");
    wr(16'hFF01, 8'h08);
    rd(16'hFF01, 8'h01, "status_ovf_clr");

    // Push into full FIFO while popping
    for (int i = 0; i < 8; i++) begin
      wr(16'hFF00, 8'(8'h11 + i));
      tx_exp_q.push_back(8'(8'h11 + i));
    end
    rd(16'hFF01, 8'h02, "status_full");
    bus.tx_ready = 1'b1;
    tx_exp_q.push_back(8'h55);
    cyc(16'hFF00, 1'b1, 8'h55, 1'b1, 8'h08, "count_full_pushpop");
    rd(16'hFF00, 8'h08, "count_after_pushpop");
    rd(16'hFF01, 8'h00, "status_partial");
    drain();
    bus.tx_ready = 1'b0;
    rd(16'hFF01, 8'h01, "status_no_ovf");

    // Timer: reload 3, period 4
    wr(16'hFF02, 8'h03);
    wr(16'hFF03, 8'h00);
    wr(16'hFF04, 8'h03);
    imm(2, 8'h00, "irq_c0");
    idle();
    idle();
    idle();
    imm(2, 8'h00, "irq_c3");
    idle();
    imm(2, 8'h01, "irq_c4");
    rd(16'hFF01, 8'h05, "status_flag");
    rd(16'hFF02, 8'h03, "tmr_lo_reload");
    rd(16'hFF03, 8'h00, "tmr_hi_reload");
    rd(16'hFF04, 8'h03, "ctrl_read");
    wr(16'hFF01, 8'h04);
    imm(2, 8'h00, "irq_cleared");
    idle();
    idle();
    imm(2, 8'h00, "irq_c11");
    idle();
    imm(2, 8'h01, "irq_c12");
    idle();
    idle();
    idle();
    wr(16'hFF01, 8'h04);
    imm(2, 8'h01, "irq_set_wins");
    rd(16'hFF01, 8'h05, "status_set_wins");
    wr(16'hFF04, 8'h01);
    imm(2, 8'h00, "irq_masked");
    rd(16'hFF04, 8'h01, "ctrl_masked");

    // Reset with queued bytes and the timer running
    wr(16'hFF04, 8'h03);
    wr(16'hFF00, 8'hAA);
    wr(16'hFF00, 8'hBB);
    wr(16'hFF00, 8'hCC);
    rd(16'h0200, 8'hA5, "ram_pre_rst");
    imm(1, 8'h01, "pre_rst_tx_valid");
    imm(2, 8'h01, "pre_rst_irq");
    cyc(16'h0200, 1'b0, 8'h00, 1'b0, 8'h00, "");
    rst_n = 1'b0;
    imm(0, 8'h00, "async_rst_dataout");
    imm(1, 8'h00, "async_rst_tx_valid");
    imm(2, 8'h00, "async_rst_irq");
    imm(3, 8'h00, "async_rst_tx_data");
    idle();
    idle();
    rst_n = 1'b1;
    wr(16'h0300, 8'h5A);
    rd(16'h0300, 8'h5A, "first_edge_wr");
    rd(16'h0200, 8'hA5, "ram_kept");
    rd(16'hFF01, 8'h01, "post_rst_status");
    rd(16'hFF00, 8'h00, "post_rst_count");
    rd(16'hFF04, 8'h00, "post_rst_ctrl");
    rd(16'hFF02, 8'hFF, "post_rst_reload");
    idle();
    idle();
    done = 1'b1;
  end

endmodule
